// File: rtl/sd_to_binary_otf.sv
// On-the-fly converter from MSD-first signed-digit (plus/minus pair) stream to two's complement.
// Optional define SD_OTF_QM_OUT_EN exposes the Q-1 companion register on port qm.
module sd_to_binary_otf #(
  parameter int unsigned DIGITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              digit_valid,
  input  logic              d_plus,
  input  logic              d_minus,
  output logic              ready,
  output logic              busy,
  output logic [DIGITS:0]   q,
`ifdef SD_OTF_QM_OUT_EN
  output logic [DIGITS:0]   qm,
`endif
  output logic              q_valid
);

  localparam int unsigned CW = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [DIGITS:0] q_q, qm_q;
  logic [DIGITS:0] q_d, qm_d;
  logic [CW-1:0]   cnt_q;
  logic            ready_q, busy_q, qv_q;
  logic            accept;
  logic            dpos, dneg;

  assign dpos   = d_plus & ~d_minus;
  assign dneg   = d_minus & ~d_plus;
  assign accept = (state_q == CONV) && digit_valid && !start;

  // Both candidates are shifted copies of Q or QM; no carry chain is needed.
  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (dpos) begin
      q_d  = {q_q[DIGITS-1:0], 1'b1};
      qm_d = {q_q[DIGITS-1:0], 1'b0};
    end else if (dneg) begin
      q_d  = {qm_q[DIGITS-1:0], 1'b1};
      qm_d = {qm_q[DIGITS-1:0], 1'b0};
    end else begin
      q_d  = {q_q[DIGITS-1:0], 1'b0};
      qm_d = {qm_q[DIGITS-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      qv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          qv_q <= 1'b0;
          if (start) begin
            state_q <= CONV;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          if (start) begin
            q_q   <= '0;
            qm_q  <= '1;
            cnt_q <= '0;
          end else if (accept) begin
            q_q   <= q_d;
            qm_q  <= qm_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(DIGITS - 1)) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              qv_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          qv_q <= 1'b0;
          if (start) begin
            state_q <= CONV;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          qv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign q       = q_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign q_valid = qv_q;
`ifdef SD_OTF_QM_OUT_EN
  assign qm      = qm_q;
`endif

endmodule
